fml_arb4: RTL and testbench
===========================

FML_ARB4 -- requirements
Module: fml_arb4

Interface
REQ-001 The block SHALL have parameter adr_width, default 28, the FML byte address width.
REQ-002 The block SHALL have parameter burst_len, default 4, the number of 64-bit beats per FML transaction.
REQ-003 The block SHALL have port sys_clk, input, 1, the single clock; all logic rises on it.
REQ-004 The block SHALL have port sys_rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports mN_adr (N=0..3), input, adr_width, master N address.
REQ-006 The block SHALL have ports mN_stb, input, 1, master N request, held until its ack.
REQ-007 The block SHALL have ports mN_we, input, 1, master N write (1) / read (0).
REQ-008 The block SHALL have ports mN_ack, output, 1, one-cycle acknowledge to master N.
REQ-009 The block SHALL have ports mN_sel and mN_di, input, 8 and 64, master N write byte-enables and data.
REQ-010 The block SHALL have ports mN_do, output, 64, read data broadcast to master N.
REQ-011 The block SHALL have slave-side ports s_adr (out, adr_width), s_stb (out, 1), s_we (out, 1), s_ack (in, 1), s_sel (out, 8), s_di (out, 64), s_do (in, 64), connecting to the DDR3 FML controller.

Function
REQ-012 The block SHALL run an FSM with states IDLE, ADDR and DATA.
REQ-013 In IDLE with any mN_stb high, the block SHALL register grant = first requester at or after rr_ptr (wrapping 3->0) and enter ADDR the next cycle.
REQ-014 In ADDR, s_adr, s_we and s_stb SHALL combinationally follow the granted master's adr, we and stb.
REQ-015 In ADDR, s_ack SHALL pass combinationally to the granted mN_ack only; all other mN_ack SHALL stay 0.
REQ-016 On s_ack in ADDR, the FSM SHALL enter DATA with beat counter 0, and rr_ptr SHALL become grant+1 mod 4.
REQ-017 In DATA, the counter SHALL increment each cycle; s_sel/s_di SHALL carry the granted master's sel/di; DATA SHALL last exactly burst_len cycles.
REQ-018 Outside DATA, s_sel and s_di SHALL be 0.
REQ-019 s_do SHALL be routed to all mN_do unregistered at all times; only the granted master interprets it.
REQ-020 On the last DATA beat, if any mN_stb is high, the block SHALL arbitrate as in IDLE and enter ADDR directly (zero idle gap); otherwise it SHALL enter IDLE.
REQ-021 If the granted mN_stb drops in ADDR before s_ack (protocol abort), the block SHALL return to IDLE with no ack and rr_ptr unchanged.
REQ-022 s_ack arriving in IDLE or DATA SHALL be ignored.
REQ-023 Requests arriving or dropping during DATA SHALL NOT affect the current grant.
REQ-024 A master still requesting SHALL be served within at most 3 other transactions (starvation bound).

Reset
REQ-025 On sys_rst low, the FSM SHALL go to IDLE, grant and rr_ptr SHALL be 0, and the beat counter SHALL be 0, all asynchronously.
REQ-026 During and right after reset, s_stb, s_we, s_adr, s_sel, s_di and all mN_ack SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it; no ack or beats SHALL follow release.

Structure
REQ-028 The FSM state encoding, the master count (4) and the default burst_len SHALL be constants in the shared FML package.
REQ-029 The round-robin pick (4 request bits + rr_ptr -> grant, valid) SHALL be a combinational sub-module fml_rr_pick, instantiated once.

Verification
REQ-030 m2 single read, ack 5 cycles after stb -> s_adr=m2_adr; m2_ack pulses once; 4 s_do beats follow; IDLE.
REQ-031 m0 write, sel=0xFF, di=0x1111..,0x2222..,0x3333..,0x4444.. -> s_di shows these 4 beats on the 4 cycles after s_ack.
REQ-032 m0..m3 request together from reset -> grants m0,m1,m2,m3, with no idle cycle between bursts.
REQ-033 m1 holds stb continuously while m3 requests -> alternates m1,m3,m1; m3 waits at most one transaction.
REQ-034 m1 drops stb in ADDR before s_ack -> no m1_ack; IDLE; next request from m1 is still granted first.
REQ-035 sys_rst pulsed low on beat 2 of a read -> all outputs 0 at once; after release, no further acks; next request granted fresh.

Source files
------------

// File: rtl/fml_arb4_pkg.sv
// Shared constants and types for the four-master FML arbiter.
package fml_arb4_pkg;

  // Number of FML masters sharing the DDR3 controller.
  localparam int NUM_MASTERS   = 4;
  // Width of a master index / round-robin pointer.
  localparam int MIDX_W        = 2;
  // Default number of 64-bit beats per FML transaction.
  localparam int FML_BURST_LEN = 4;
  // FML data path width and byte-enable width.
  localparam int FML_DW        = 64;
  localparam int FML_SW        = 8;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } fml_state_e;

  // Round-robin successor of a master index; wraps 3 -> 0 naturally.
  function automatic logic [MIDX_W-1:0] rr_next(input logic [MIDX_W-1:0] idx);
    return idx + MIDX_W'(1);
  endfunction

endpackage

// File: rtl/fml_rr_pick.sv
// Combinational round-robin pick: first requester at or after the pointer.
module fml_rr_pick
  import fml_arb4_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [MIDX_W-1:0]      ptr_i,
  output logic [MIDX_W-1:0]      grant_o,
  output logic                   valid_o
);

  // Scan from the farthest offset down to offset 0 so the nearest requester wins.
  always_comb begin
    grant_o = ptr_i;
    valid_o = |req_i;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req_i[ptr_i + MIDX_W'(k)]) begin
        grant_o = ptr_i + MIDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fml_arb4.sv
// Four-master FML arbiter in front of the DDR3 FML controller.
// Address phase is passed through combinationally from the granted master;
// the data phase lasts exactly burst_len beats after the slave ack, and a
// new grant can be issued on the last beat so bursts run back to back.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no grant active, waiting for any request
// ADDR    | granted master's address phase visible on the slave port
// DATA    | burst_len write/read beats for the granted master
module fml_arb4
  import fml_arb4_pkg::*;
#(
  parameter int adr_width = 28,
  parameter int burst_len = FML_BURST_LEN
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,

  input  logic [adr_width-1:0] m0_adr,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  output logic                 m0_ack,
  input  logic [FML_SW-1:0]    m0_sel,
  input  logic [FML_DW-1:0]    m0_di,
  output logic [FML_DW-1:0]    m0_do,

  input  logic [adr_width-1:0] m1_adr,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  output logic                 m1_ack,
  input  logic [FML_SW-1:0]    m1_sel,
  input  logic [FML_DW-1:0]    m1_di,
  output logic [FML_DW-1:0]    m1_do,

  input  logic [adr_width-1:0] m2_adr,
  input  logic                 m2_stb,
  input  logic                 m2_we,
  output logic                 m2_ack,
  input  logic [FML_SW-1:0]    m2_sel,
  input  logic [FML_DW-1:0]    m2_di,
  output logic [FML_DW-1:0]    m2_do,

  input  logic [adr_width-1:0] m3_adr,
  input  logic                 m3_stb,
  input  logic                 m3_we,
  output logic                 m3_ack,
  input  logic [FML_SW-1:0]    m3_sel,
  input  logic [FML_DW-1:0]    m3_di,
  output logic [FML_DW-1:0]    m3_do,

  output logic [adr_width-1:0] s_adr,
  output logic                 s_stb,
  output logic                 s_we,
  input  logic                 s_ack,
  output logic [FML_SW-1:0]    s_sel,
  output logic [FML_DW-1:0]    s_di,
  input  logic [FML_DW-1:0]    s_do
);

  // A one-beat burst still needs a one-bit counter.
  localparam int BEAT_W = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(burst_len - 1);

  logic [adr_width-1:0]   adr_a [NUM_MASTERS];
  logic [FML_SW-1:0]      sel_a [NUM_MASTERS];
  logic [FML_DW-1:0]      di_a  [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] stb_v;
  logic [NUM_MASTERS-1:0] we_v;
  logic [NUM_MASTERS-1:0] ack_v;

  fml_state_e        state_q, state_d;
  logic [MIDX_W-1:0] grant_q, grant_d;
  logic [MIDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic [MIDX_W-1:0] pick_grant;
  logic              pick_valid;

  assign adr_a[0] = m0_adr;
  assign adr_a[1] = m1_adr;
  assign adr_a[2] = m2_adr;
  assign adr_a[3] = m3_adr;
  assign sel_a[0] = m0_sel;
  assign sel_a[1] = m1_sel;
  assign sel_a[2] = m2_sel;
  assign sel_a[3] = m3_sel;
  assign di_a[0]  = m0_di;
  assign di_a[1]  = m1_di;
  assign di_a[2]  = m2_di;
  assign di_a[3]  = m3_di;
  assign stb_v    = {m3_stb, m2_stb, m1_stb, m0_stb};
  assign we_v     = {m3_we, m2_we, m1_we, m0_we};

  assign m0_ack = ack_v[0];
  assign m1_ack = ack_v[1];
  assign m2_ack = ack_v[2];
  assign m3_ack = ack_v[3];

  // Read data is broadcast; only the granted master consumes it.
  assign m0_do = s_do;
  assign m1_do = s_do;
  assign m2_do = s_do;
  assign m3_do = s_do;

  fml_rr_pick u_rr_pick (
    .req_i   (stb_v),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  // State, grant, round-robin pointer and beat counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Next-state logic; the pointer only advances once a transaction is accepted.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!stb_v[grant_q]) begin
          // Master withdrew its request: drop the grant, leave fairness as it was.
          state_d = ST_IDLE;
        end else if (s_ack) begin
          state_d  = ST_DATA;
          beat_d   = '0;
          rr_ptr_d = rr_next(grant_q);
        end
      end
      ST_DATA: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          if (pick_valid) begin
            grant_d = pick_grant;
            state_d = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Slave-side muxing and ack routing; everything idles at zero outside its phase.
  always_comb begin
    s_adr = '0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    s_sel = '0;
    s_di  = '0;
    ack_v = '0;
    case (state_q)
      ST_ADDR: begin
        s_adr          = adr_a[grant_q];
        s_stb          = stb_v[grant_q];
        s_we           = we_v[grant_q];
        ack_v[grant_q] = s_ack & stb_v[grant_q];
      end
      ST_DATA: begin
        s_sel = sel_a[grant_q];
        s_di  = di_a[grant_q];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fml_arb4.sv
// Randomized and directed bench for fml_arb4 with a transaction-level reference.
module tb_fml_arb4;

  localparam int AW = 28;
  localparam int BL = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [AW-1:0] b_adr [4];
  logic [3:0]    b_stb;
  logic [3:0]    b_we;
  logic [7:0]    b_sel [4];
  logic [63:0]   b_di  [4];
  logic [63:0]   m_do  [4];
  logic          m0_ack, m1_ack, m2_ack, m3_ack;
  logic [AW-1:0] s_adr;
  logic          s_stb, s_we, s_ack;
  logic [7:0]    s_sel;
  logic [63:0]   s_di, s_do;

  fml_arb4 #(.adr_width(AW), .burst_len(BL)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_adr(b_adr[0]), .m0_stb(b_stb[0]), .m0_we(b_we[0]), .m0_ack(m0_ack),
    .m0_sel(b_sel[0]), .m0_di(b_di[0]), .m0_do(m_do[0]),
    .m1_adr(b_adr[1]), .m1_stb(b_stb[1]), .m1_we(b_we[1]), .m1_ack(m1_ack),
    .m1_sel(b_sel[1]), .m1_di(b_di[1]), .m1_do(m_do[1]),
    .m2_adr(b_adr[2]), .m2_stb(b_stb[2]), .m2_we(b_we[2]), .m2_ack(m2_ack),
    .m2_sel(b_sel[2]), .m2_di(b_di[2]), .m2_do(m_do[2]),
    .m3_adr(b_adr[3]), .m3_stb(b_stb[3]), .m3_we(b_we[3]), .m3_ack(m3_ack),
    .m3_sel(b_sel[3]), .m3_di(b_di[3]), .m3_do(m_do[3]),
    .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_ack(s_ack),
    .s_sel(s_sel), .s_di(s_di), .s_do(s_do)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Master / slave behaviour
  bit            pend [4];
  int            req_left [4], gap [4], dbeat [4], acks [4], issued [4], wait_cnt [4];
  logic [AW-1:0] nadr [4];
  logic          nwe  [4];
  logic [7:0]    nsel [4];
  bit            rand_mode;
  int            lat, scnt;

  // Observations
  int            gq [$];
  int            ackc [$];
  int            risec [$];
  logic [AW-1:0] ack_adr;
  logic          prev_sstb;
  logic [63:0]   obs_sdi;
  logic [7:0]    obs_ssel;
  logic [3:0]    obs_ack;

  // Reference: phase of the arbiter as seen by the bus (0 idle, 1 address, 2 data)
  int mphase, mg, mptr, mleft;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] dpat(input int n, input int b);
    logic [63:0] base;
    base = 64'h1111_1111_1111_1111;
    return (base * 64'(b + 1)) ^ (64'(n) << 60);
  endfunction

  // First requester at or after ptr, wrapping modulo 4.
  function automatic int rr_first(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int n = 0; n < 4; n++) begin
      b_di[n] = (dbeat[n] >= 0) ? dpat(n, dbeat[n]) : {$urandom, $urandom};
      if (!pend[n] && req_left[n] > 0 && gap[n] == 0) begin
        if (rand_mode) begin
          nadr[n] = AW'($urandom);
          nwe[n]  = 1'($urandom);
          nsel[n] = 8'($urandom);
          gap[n]  = $urandom_range(0, 3);
        end
        pend[n]     = 1'b1;
        req_left[n] = req_left[n] - 1;
        issued[n]   = issued[n] + 1;
        wait_cnt[n] = 0;
        b_adr[n]    = nadr[n];
        b_we[n]     = nwe[n];
        b_sel[n]    = nsel[n];
      end else if (!pend[n] && gap[n] > 0) begin
        gap[n] = gap[n] - 1;
      end
      b_stb[n] = pend[n];
    end
    s_ack = (scnt >= lat);
    s_do  = {$urandom, $urandom};
  endtask

  task automatic step();
    logic [AW-1:0] e_adr;
    logic          e_stb, e_we;
    logic [7:0]    e_sel;
    logic [63:0]   e_di;
    logic [3:0]    e_ack;
    drive();
    #1;
    obs_ack  = {m3_ack, m2_ack, m1_ack, m0_ack};
    obs_sdi  = s_di;
    obs_ssel = s_sel;
    if (!sys_rst) begin
      mphase = 0; mg = 0; mptr = 0; mleft = 0;
    end
    e_adr = '0; e_stb = 1'b0; e_we = 1'b0; e_sel = '0; e_di = '0; e_ack = '0;
    if (mphase == 1) begin
      e_adr     = b_adr[mg];
      e_stb     = b_stb[mg];
      e_we      = b_we[mg];
      e_ack[mg] = s_ack & b_stb[mg];
    end else if (mphase == 2) begin
      e_sel = b_sel[mg];
      e_di  = b_di[mg];
    end
    check("s_stb", 64'(s_stb), 64'(e_stb));
    check("s_we", 64'(s_we), 64'(e_we));
    check("s_adr", 64'(s_adr), 64'(e_adr));
    check("s_sel", 64'(s_sel), 64'(e_sel));
    check("s_di", s_di, e_di);
    check("m_ack", 64'(obs_ack), 64'(e_ack));
    for (int n = 0; n < 4; n++) check("m_do", m_do[n], s_do);

    if (s_stb && !prev_sstb) risec.push_back(cyc);
    prev_sstb = s_stb;
    for (int n = 0; n < 4; n++) begin
      if (dbeat[n] >= 0) begin
        dbeat[n] = dbeat[n] + 1;
        if (dbeat[n] == BL) dbeat[n] = -1;
      end
    end
    for (int n = 0; n < 4; n++) begin
      if (obs_ack[n]) begin
        acks[n] = acks[n] + 1;
        gq.push_back(n);
        ackc.push_back(cyc);
        ack_adr = s_adr;
        check("starve", 64'(wait_cnt[n] <= 3), 64'd1);
        for (int m = 0; m < 4; m++) if (m != n && pend[m]) wait_cnt[m] = wait_cnt[m] + 1;
        pend[n]  = 1'b0;
        dbeat[n] = 0;
        if (rand_mode) lat = $urandom_range(0, 4);
      end
    end
    if (s_stb && obs_ack == 4'b0) scnt = scnt + 1;
    else scnt = 0;

    if (sys_rst) begin
      case (mphase)
        0: if (|b_stb) begin mg = rr_first(b_stb, mptr); mphase = 1; end
        1: begin
          if (!b_stb[mg]) mphase = 0;
          else if (s_ack) begin mphase = 2; mleft = BL; mptr = (mg + 1) % 4; end
        end
        default: begin
          mleft = mleft - 1;
          if (mleft == 0) begin
            if (|b_stb) begin mg = rr_first(b_stb, mptr); mphase = 1; end
            else mphase = 0;
          end
        end
      endcase
    end
    @(negedge sys_clk);
    cyc++;
  endtask

  task automatic clear_logs();
    gq.delete(); ackc.delete(); risec.delete();
  endtask

  task automatic do_reset();
    sys_rst   = 1'b0;
    rand_mode = 1'b0;
    scnt      = 0;
    for (int n = 0; n < 4; n++) begin
      pend[n] = 1'b0; req_left[n] = 0; gap[n] = 0; dbeat[n] = -1;
      acks[n] = 0; issued[n] = 0; wait_cnt[n] = 0;
    end
    step();
    step();
    sys_rst = 1'b1;
    clear_logs();
  endtask

  task automatic wait_ack(input int n, input int maxc, input string tag);
    int a0;
    int k;
    a0 = acks[n];
    k  = 0;
    while (acks[n] == a0 && k < maxc) begin
      step();
      k++;
    end
    check(tag, 64'(acks[n] - a0), 64'd1);
  endtask

  initial begin
    logic [63:0] exp_di [4];
    int          a_sum;
    int          k;
    bit          done;
    exp_di[0] = 64'h1111_1111_1111_1111;
    exp_di[1] = 64'h2222_2222_2222_2222;
    exp_di[2] = 64'h3333_3333_3333_3333;
    exp_di[3] = 64'h4444_4444_4444_4444;
    for (int n = 0; n < 4; n++) begin
      b_adr[n] = '0; b_sel[n] = '0; b_di[n] = '0;
      nadr[n] = '0; nwe[n] = 1'b0; nsel[n] = '0;
    end
    b_stb = '0; b_we = '0; s_ack = 1'b0; s_do = '0;
    prev_sstb = 1'b0; lat = 1;
    mphase = 0; mg = 0; mptr = 0; mleft = 0;
    @(negedge sys_clk);

    // m2 single read, slave acks 5 cycles after strobe
    do_reset();
    nadr[2] = 28'h0ABCDE0; nwe[2] = 1'b0; nsel[2] = 8'h0F;
    lat = 5; req_left[2] = 1;
    wait_ack(2, 20, "t1_ack");
    check("t1_adr", 64'(ack_adr), 64'h0ABCDE0);
    check("t1_lat", 64'(ackc[0] - risec[0]), 64'd5);
    repeat (BL + 4) step();
    check("t1_ack_once", 64'(acks[2]), 64'd1);

    // m0 write, byte enables all set, four data beats follow the ack
    do_reset();
    nadr[0] = 28'h0000100; nwe[0] = 1'b1; nsel[0] = 8'hFF;
    lat = 2; req_left[0] = 1;
    wait_ack(0, 20, "t2_ack");
    for (int b = 0; b < 4; b++) begin
      step();
      check("t2_di", obs_sdi, exp_di[b]);
      check("t2_sel", 64'(obs_ssel), 64'hFF);
    end
    step();
    check("t2_di_after", obs_sdi, 64'd0);

    // all four request together from reset: 0,1,2,3 back to back
    do_reset();
    for (int n = 0; n < 4; n++) begin
      nadr[n] = AW'(32'h100 + n * 16); nwe[n] = 1'(n); nsel[n] = 8'(n + 1);
      req_left[n] = 1;
    end
    lat = 1;
    repeat (40) step();
    check("t3_count", 64'(gq.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t3_order", 64'(gq[i]), 64'(i));
    for (int i = 0; i < 3; i++) check("t3_gap", 64'(risec[i + 1] - ackc[i]), 64'(BL + 1));

    // m1 holds its request while m3 asks once: 1,3,1
    do_reset();
    nadr[1] = 28'h0001000; nadr[3] = 28'h0003000; nwe[1] = 1'b0; nwe[3] = 1'b1;
    lat = 1; req_left[1] = 2; req_left[3] = 1;
    repeat (40) step();
    check("t4_count", 64'(gq.size()), 64'd3);
    check("t4_g0", 64'(gq[0]), 64'd1);
    check("t4_g1", 64'(gq[1]), 64'd3);
    check("t4_g2", 64'(gq[2]), 64'd1);

    // m1 abandons its request during the address phase
    do_reset();
    nadr[1] = 28'h0002220; lat = 20; req_left[1] = 1;
    repeat (3) step();
    pend[1] = 1'b0;
    repeat (6) step();
    check("t5_no_ack", 64'(acks[1]), 64'd0);
    lat = 1; req_left[1] = 1; req_left[2] = 1; nadr[2] = 28'h0004440;
    repeat (14) step();
    check("t5_count", 64'(gq.size() >= 1), 64'd1);
    check("t5_first", 64'(gq[0]), 64'd1);

    // reset pulse on the third beat of a read
    do_reset();
    nadr[0] = 28'h0005550; nwe[0] = 1'b0; lat = 1; req_left[0] = 1;
    wait_ack(0, 20, "t6_ack");
    step();
    step();
    sys_rst = 1'b0;
    step();
    check("t6_rst_out", {s_stb, s_we, |s_adr, |obs_ssel, |obs_sdi, |obs_ack}, 64'd0);
    step();
    sys_rst = 1'b1;
    a_sum = acks[0] + acks[1] + acks[2] + acks[3];
    repeat (10) step();
    check("t6_no_ack", 64'(acks[0] + acks[1] + acks[2] + acks[3] - a_sum), 64'd0);
    clear_logs();
    nadr[1] = 28'h0006660; nadr[3] = 28'h0007770; req_left[1] = 1; req_left[3] = 1;
    repeat (14) step();
    check("t6_first", 64'(gq[0]), 64'd1);

    // randomized traffic against the reference
    do_reset();
    rand_mode = 1'b1;
    lat = $urandom_range(0, 4);
    for (int n = 0; n < 4; n++) begin
      req_left[n] = $urandom_range(6, 12);
      gap[n]      = $urandom_range(0, 3);
    end
    k = 0;
    done = 1'b0;
    while (!done && k < 4000) begin
      step();
      k++;
      done = 1'b1;
      for (int n = 0; n < 4; n++) if (req_left[n] != 0 || pend[n]) done = 1'b0;
    end
    check("rnd_drained", 64'(done), 64'd1);
    repeat (BL + 3) step();
    for (int n = 0; n < 4; n++) check("rnd_acks", 64'(acks[n]), 64'(issued[n]));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
